forwarding_hazard_unit: RTL and testbench

FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

---
 rtl/forwarding_hazard_unit.sv | 123 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for a 5-stage pipeline.
// Shadows the EX/MEM/WB slots and derives forwarding selects, stall and bubble.
module forwarding_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             memAdelant_rs,
    output logic             memAdelant_rt,
    output logic             wbAdelant_rs,
    output logic             wbAdelant_rt,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    logic             r_ex_valid;
    logic [4:0]       r_ex_rs;
    logic [4:0]       r_ex_rt;
    logic [4:0]       r_ex_dst;
    logic             r_ex_regwrite;
    logic             r_ex_memread;
    logic             r_mem_valid;
    logic [4:0]       r_mem_dst;
    logic             r_mem_regwrite;
    logic             r_wb_valid;
    logic [4:0]       r_wb_dst;
    logic             r_wb_regwrite;
    logic [CNT_W-1:0] r_stall_count;

    logic       w_load_use;
    logic       w_stall;
    logic       w_ex_load;
    logic [4:0] w_ex_src [2];
    logic [1:0] w_mem_fwd;
    logic [1:0] w_wb_fwd;

    // Load in EX whose result is consumed by the instruction now in ID.
    assign w_load_use = r_ex_valid && r_ex_memread && r_ex_regwrite
                        && (r_ex_dst != 5'd0) && id_valid
                        && ((r_ex_dst == id_rs) || (r_ex_dst == id_rt));

    assign w_stall   = w_load_use && !flush && !reset;
    assign w_ex_load = id_valid && !w_stall && !flush;

    assign stall  = w_stall;
    assign bubble = (w_load_use || flush) && !reset;

    assign w_ex_src[0] = r_ex_rs;
    assign w_ex_src[1] = r_ex_rt;

    // Index 0 is the rs operand, index 1 the rt operand; MEM wins over WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_mem_writes;
            logic w_wb_writes;
            assign w_mem_writes = r_mem_valid && r_mem_regwrite
                                  && (r_mem_dst == w_ex_src[gi]) && (w_ex_src[gi] != 5'd0);
            assign w_wb_writes  = r_wb_valid && r_wb_regwrite
                                  && (r_wb_dst == w_ex_src[gi]) && (w_ex_src[gi] != 5'd0);
            assign w_mem_fwd[gi] = r_ex_valid && w_mem_writes;
            assign w_wb_fwd[gi]  = r_ex_valid && w_wb_writes && !w_mem_fwd[gi];
        end
    endgenerate

    assign memAdelant_rs = w_mem_fwd[0];
    assign memAdelant_rt = w_mem_fwd[1];
    assign wbAdelant_rs  = w_wb_fwd[0];
    assign wbAdelant_rt  = w_wb_fwd[1];
    assign stall_count   = r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= 5'd0;
            r_ex_rt        <= 5'd0;
            r_ex_dst       <= 5'd0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_dst      <= 5'd0;
            r_mem_regwrite <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_dst       <= 5'd0;
            r_wb_regwrite  <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_dst       <= r_mem_dst;
            r_wb_regwrite  <= r_mem_regwrite;
            r_mem_valid    <= r_ex_valid;
            r_mem_dst      <= r_ex_dst;
            r_mem_regwrite <= r_ex_regwrite;
            // Bubbles carry zeroed fields so a dead slot never matches anything.
            if (w_ex_load) begin
                r_ex_valid    <= 1'b1;
                r_ex_rs       <= id_rs;
                r_ex_rt       <= id_rt;
                r_ex_dst      <= id_dst;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
            end else begin
                r_ex_valid    <= 1'b0;
                r_ex_rs       <= 5'd0;
                r_ex_rt       <= 5'd0;
                r_ex_dst      <= 5'd0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_forwarding_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_regwrite, id_memread, flush;
    logic        mem_rs, mem_rt, wb_rs, wb_rt, stall, bubble;
    logic [15:0] cnt;
    logic        mem_rs2, mem_rt2, wb_rs2, wb_rt2, stall2, bubble2;
    logic [1:0]  cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .memAdelant_rs(mem_rs), .memAdelant_rt(mem_rt), .wbAdelant_rs(wb_rs),
        .wbAdelant_rt(wb_rt), .stall(stall), .bubble(bubble), .stall_count(cnt)
    );

    forwarding_hazard_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .memAdelant_rs(mem_rs2), .memAdelant_rt(mem_rt2), .wbAdelant_rs(wb_rs2),
        .wbAdelant_rt(wb_rt2), .stall(stall2), .bubble(bubble2), .stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fwd(input string tag, input logic e_mrs, input logic e_mrt,
                       input logic e_wrs, input logic e_wrt);
        chk({tag, ".mem_rs"}, 32'(mem_rs), 32'(e_mrs));
        chk({tag, ".mem_rt"}, 32'(mem_rt), 32'(e_mrt));
        chk({tag, ".wb_rs"},  32'(wb_rs),  32'(e_wrs));
        chk({tag, ".wb_rt"},  32'(wb_rt),  32'(e_wrt));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b1;
        set_id(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.bubble", 32'(bubble), 32'd0);
        chk("rst.count", 32'(cnt), 32'd0);
        fwd("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        flush = 1'b0;

        // Back-to-back ALU dependency: add $3, then consumers of $3
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
        chk("alu.stall", 32'(stall), 32'd0);
        chk("alu.bubble", 32'(bubble), 32'd0);
        tick();
        fwd("alu.mem", 1'b1, 1'b0, 1'b0, 1'b0);
        set_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0);
        tick();
        fwd("alu.wb", 1'b0, 1'b0, 1'b1, 1'b0);

        // Double hazard: MEM and WB both write $5, EX reads $5 on both operands
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0);
        tick();
        fwd("dbl", 1'b1, 1'b1, 1'b0, 1'b0);

        // Load-use on $7
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
        chk("lu.stall", 32'(stall), 32'd1);
        chk("lu.bubble", 32'(bubble), 32'd1);
        chk("lu.count0", 32'(cnt), 32'd0);
        tick();
        chk("lu.stall_once", 32'(stall), 32'd0);
        chk("lu.bubble_once", 32'(bubble), 32'd0);
        chk("lu.count1", 32'(cnt), 32'd1);
        fwd("lu.hole", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        fwd("lu.fwd", 1'b0, 1'b0, 1'b1, 1'b0);

        // Register zero: lw $0 followed by a reader of $0
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("r0.stall", 32'(stall), 32'd0);
        chk("r0.bubble", 32'(bubble), 32'd0);
        tick();
        fwd("r0", 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush overrides a pending load-use on $2
        set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd0, 5'd2, 5'd10, 1'b1, 1'b0);
        chk("fl.stall", 32'(stall), 32'd0);
        chk("fl.bubble", 32'(bubble), 32'd1);
        tick();
        flush = 1'b0;
        chk("fl.count", 32'(cnt), 32'd1);
        set_id(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0);
        tick();
        fwd("fl.squashed", 1'b0, 1'b0, 1'b0, 1'b0);

        // Four more load-use stalls: total 5, narrow counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd0, 5'd12, 5'd1, 1'b1, 1'b0);
            chk("sat.stall", 32'(stall), 32'd1);
            tick();
            tick();
        end
        chk("sat.count16", 32'(cnt), 32'd5);
        chk("sat.count2", 32'(cnt2), 32'd3);

        // Reset between edges during a stall
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd13, 5'd0, 5'd1, 1'b1, 1'b0);
        chk("mrst.stall_pre", 32'(stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst.stall", 32'(stall), 32'd0);
        chk("mrst.bubble", 32'(bubble), 32'd0);
        chk("mrst.count", 32'(cnt), 32'd0);
        fwd("mrst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // First edge after release loads EX normally
        set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd14, 5'd14, 5'd1, 1'b1, 1'b0);
        tick();
        fwd("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst.count", 32'(cnt), 32'd0);

        // Invalid ID instruction never stalls
        set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("idinv.stall", 32'(stall), 32'd0);
        chk("idinv.bubble", 32'(bubble), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
